// File: rtl/neuron_mac_sequencer.sv
// Single-neuron MAC sequencer: strobes the weight/bias memory, accumulates
// bias plus NUM_IN weight*activation products, then shifts, ReLUs and saturates to Q9.6.
module neuron_mac_sequencer #(
    parameter int NUM_IN = 4,
    parameter int W      = 16,
    parameter int FRAC   = 6,
    parameter int ACC_W  = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_IN*W-1:0] x_in,
    input  logic [5:0]          neuron_sel,
    input  logic [5:0]          group_sel,
    input  logic                relu_en,
    output logic                weight_en,
    output logic                bias_en,
    output logic [5:0]          n,
    output logic [5:0]          i,
    input  logic [W-1:0]        wt_data,
    input  logic [W-1:0]        bias_data,
    output logic                busy,
    output logic                done,
    output logic [W-1:0]        y
);

    localparam int IDX_W = (NUM_IN > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        WGT,
        DRAIN,
        OUT
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          wgtCnt_q, wgtCnt_d;
    logic [IDX_W-1:0]          wgtIdx_q;
    logic                      wgtVld_q;
    logic                      biasVld_q;
    logic signed [W-1:0]       xReg_q [NUM_IN];
    logic [5:0]                nSel_q;
    logic [5:0]                gSel_q;
    logic                      relu_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [W-1:0]              y_q;
    logic                      done_q;

    logic signed [2*W-1:0]     prod;
    logic [ACC_W-1:0]          prodExt;
    logic [ACC_W-1:0]          biasExt;
    logic signed [ACC_W-1:0]   shifted;
    logic                      inRange;
    logic [W-1:0]              result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wgtCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wgtCnt_q <= wgtCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wgtCnt_d  = wgtCnt_q;
        weight_en = 1'b0;
        bias_en   = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = BIAS;
            end
            BIAS: begin
                bias_en  = 1'b1;
                wgtCnt_d = '0;
                state_d  = WGT;
            end
            WGT: begin
                weight_en = 1'b1;
                if (wgtCnt_q == IDX_W'(NUM_IN - 1)) begin
                    state_d = DRAIN;
                end else begin
                    wgtCnt_d = wgtCnt_q + 1'b1;
                end
            end
            DRAIN:   state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory data arrives one cycle after its strobe, so the delayed flags/index pair it up.
    assign prod    = xReg_q[wgtIdx_q] * $signed(wt_data);
    assign prodExt = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    assign biasExt = {{(ACC_W-W-FRAC){bias_data[W-1]}}, bias_data, {FRAC{1'b0}}};

    assign shifted = acc_q >>> FRAC;
    assign inRange = (&shifted[ACC_W-1:W-1]) | ~(|shifted[ACC_W-1:W-1]);

    always_comb begin
        result = shifted[W-1:0];
        if (relu_q && shifted[ACC_W-1]) begin
            result = '0;
        end else if (!inRange) begin
            result = shifted[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_IN; k++) xReg_q[k] <= '0;
            nSel_q    <= '0;
            gSel_q    <= '0;
            relu_q    <= 1'b0;
            biasVld_q <= 1'b0;
            wgtVld_q  <= 1'b0;
            wgtIdx_q  <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            biasVld_q <= (state_q == BIAS);
            wgtVld_q  <= (state_q == WGT);
            wgtIdx_q  <= wgtCnt_q;
            if (state_q == IDLE && start) begin
                for (int k = 0; k < NUM_IN; k++) xReg_q[k] <= x_in[k*W +: W];
                nSel_q <= neuron_sel;
                gSel_q <= group_sel;
                relu_q <= relu_en;
            end
            if (biasVld_q) begin
                acc_q <= biasExt;
            end else if (wgtVld_q) begin
                acc_q <= acc_q + prodExt;
            end
            if (state_q == OUT) begin
                y_q    <= result;
                done_q <= 1'b1;
            end
        end
    end

    assign n    = nSel_q;
    assign i    = gSel_q;
    assign y    = y_q;
    assign done = done_q;

endmodule

// File: doc/neuron_mac_sequencer.md
Name: neuron_mac_sequencer

Overview:
- Computes one neuron output from NUM_IN activations plus a bias, using the weight/bias memory (registered read, 1-cycle latency, internal auto-increment weight counter) as its coefficient source.
- Sequences the memory read strobes (weight_en, bias_en, n, i), multiplies each returned weight with the latched activation, and accumulates.
- Adds the bias, applies optional ReLU, saturates, and presents a Q9.6 result with a done pulse. The layer controller invokes it once per neuron.

Parameters:
- NUM_IN, 4, activations/weights per neuron (2..4; the memory counter addresses at most 4).
- W, 16, data width (signed, two's complement).
- FRAC, 6, fractional bits (1.0 = 0x0040).
- ACC_W, 40, accumulator width (signed).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one neuron; sampled only in IDLE.
- x_in  in  NUM_IN*W  packed activations, x0 in LSBs; latched at accepted start.
- neuron_sel  in  6  neuron index; latched at start and driven on n.
- group_sel  in  6  input-group index; latched at start and driven on i.
- relu_en  in  1  apply ReLU; latched at start.
- weight_en  out  1  memory weight read strobe.
- bias_en  out  1  memory bias read strobe.
- n  out  6  memory neuron address.
- i  out  6  memory group address.
- wt_data  in  W  weight from memory; valid the cycle after a weight_en cycle.
- bias_data  in  W  bias from memory; valid the cycle after a bias_en cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; y valid.
- y  out  W  neuron result in Q9.6; holds until the next done.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - weight_en=0, bias_en=0, n=0, i=0, busy=0, done=0, y=0.
  - accumulator=0, latched operands=0.
- States: IDLE -> BIAS -> WGT -> DRAIN -> OUT -> IDLE.
- Cycle timing, with edge E0 the edge that samples start=1 in IDLE:
  - BIAS (after E0): bias_en=1 for exactly one cycle, weight_en=0.
  - WGT (after E1 .. after E_NUM_IN): weight_en=1 for exactly NUM_IN consecutive cycles; the memory returns w0..w(NUM_IN-1) in order.
  - E2: acc <= sign_ext(bias_data) << FRAC (Q2*FRAC alignment).
  - E(j+3), j=0..NUM_IN-1: acc <= acc + sign_ext(x_j * wt_data). The product is a full 2W-bit signed product. A 1-cycle delayed valid flag pairs each wt_data with its index j.
  - DRAIN (after E(NUM_IN+1)): weight_en=0, which also clears the memory's internal counter before the next neuron.
  - E(NUM_IN+2): last product accumulated; state -> OUT.
  - E(NUM_IN+3), result stage, in this order:
    - r = acc >>> FRAC (arithmetic shift, rounds toward minus infinity).
    - If relu_en and r<0, r=0.
    - Saturate r to [0x8000, 0x7FFF].
    - y <= r, done <= 1, state -> IDLE.
  - done is therefore high in the cycle after E(NUM_IN+3), i.e. 7 edges after start for NUM_IN=4.
- n and i hold the latched values from BIAS through DRAIN and are held unchanged in IDLE.
- start while busy: ignored. There is no queuing.
- start high in the same cycle done is high: accepted (state is IDLE), giving back-to-back neurons. bias_en follows immediately; weight_en has already been low for at least one cycle.
- weight_en and bias_en are never high in the same cycle.
- weight_en is never high for more than NUM_IN consecutive cycles.
- No internal overflow: ACC_W=40 covers NUM_IN=4 full-scale products plus bias.

Test Plan:
- Basic sum: memory n=0,i=0 weights {0x0040, 0x0080, 0, 0}, bias 0x0078; x={0x0040, 0x0040, 0x0100, 0x0100}, relu_en=0 -> y=0x0138 (4.875); done exactly 7 cycles after start; busy high for 7 cycles.
- Sign/ReLU: w0=0xFFC0 (-1.0), x0=0x00C0 (3.0), other terms 0, bias 0x0040 -> y=0xFF80 with relu_en=0; y=0x0000 with relu_en=1.
- Truncation/saturation:
  - x0=0x0001, w0=0xFFE0, bias 0 -> y=0xFFFF.
  - All x=0x7FFF, all w=0x7FFF -> y=0x7FFF.
  - x=0x7FFF, w=0x8000 (all four) -> y=0x8000.
- Strobe protocol: monitor checks that bias_en is a single cycle immediately followed by exactly 4 weight_en cycles, then weight_en low; n/i equal neuron_sel/group_sel (e.g. 3/1) throughout; a second start pulse during busy produces no extra done.
- Reset mid-operation: assert rst_n=0 during the 2nd weight_en cycle -> all outputs 0 asynchronously. After release, a fresh start gives correct y (re-run the basic-sum case; y=0x0138).
- Back-to-back: start held high for 3 consecutive neurons (n=0,1,2) -> done pulses every 8 cycles; each y matches the reference model; weight_en drops for at least 1 cycle between neurons.
